// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: DW_DIVIDEND-bit dividend over DW_DIVISOR-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int unsigned DW_DIVIDEND = 8,
  parameter int unsigned DW_DIVISOR  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DW_DIVIDEND-1:0] dividend,
  input  logic [DW_DIVISOR-1:0]  divisor,
  output logic                   busy,
  output logic                   done,
  output logic [DW_DIVIDEND-1:0] quotient,
  output logic [DW_DIVISOR-1:0]  remainder,
  output logic                   div_by_zero
);

  localparam int unsigned CW = (DW_DIVIDEND > 1) ? $clog2(DW_DIVIDEND) : 1;
  localparam int unsigned PW = DW_DIVISOR + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [DW_DIVIDEND-1:0] r_quot;
  logic [DW_DIVISOR-1:0]  r_rem;
  logic                   r_dbz;
  logic [CW-1:0]          r_cnt;
  logic [DW_DIVISOR-1:0]  r_divisor;
  logic [DW_DIVIDEND-1:0] r_work;
  logic [PW-1:0]          r_part;

  logic [PW-1:0]          w_shift;
  logic [PW:0]            w_trial;
  logic                   w_ge;
  logic [PW-1:0]          w_part_nxt;
  logic [DW_DIVIDEND-1:0] w_work_nxt;

  // One restoring step: the partial remainder stays below the divisor, so its
  // top bit is always zero and the shifted value still fits in PW bits.
  always_comb begin
    w_shift    = {r_part[DW_DIVISOR-1:0], r_work[DW_DIVIDEND-1]};
    w_trial    = {1'b0, w_shift} - {2'b00, r_divisor};
    w_ge       = ~w_trial[PW];
    w_part_nxt = w_ge ? w_trial[PW-1:0] : w_shift;
    w_work_nxt = {r_work[DW_DIVIDEND-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_work    <= '0;
      r_part    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= dividend[DW_DIVISOR-1:0];
              r_dbz   <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              r_busy    <= 1'b1;
              r_divisor <= divisor;
              r_work    <= dividend;
              r_part    <= '0;
              r_cnt     <= '0;
            end
          end
        end
        S_RUN: begin
          r_part <= w_part_nxt;
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW_DIVIDEND - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_work_nxt;
            r_rem   <= w_part_nxt[DW_DIVISOR-1:0];
            r_dbz   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, random operands,
// and an exhaustive back-to-back sweep against an arithmetic reference.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  int last_q = 0;
  int last_r = 0;
  int last_z = 0;

  seq_restoring_divider #(.DW_DIVIDEND(8), .DW_DIVISOR(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 4x4 product by vertical-and-crosswise column sums
  function automatic int vedic4x4(input logic [3:0] a, input logic [3:0] b);
    int p;
    int col;
    int j;
    p = 0;
    for (int k = 0; k < 7; k++) begin
      col = 0;
      for (int i = 0; i < 4; i++) begin
        j = k - i;
        if (j >= 0 && j < 4) col += int'(a[i] & b[j]);
      end
      p += col << k;
    end
    return p;
  endfunction

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? 255 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? (a % 16) : (a % b);
  endfunction

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_done(output int bc, output bit tmo);
    bc  = 0;
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string tag, input int a, input int b);
    int bc;
    bit tmo;
    launch(8'(a), 4'(b));
    if (b != 0) check({tag, "_hold_q"}, 32'(quotient), 32'(last_q));
    wait_done(bc, tmo);
    check({tag, "_timeout"}, 32'(tmo), 0);
    check({tag, "_busy_cycles"}, 32'(bc), (b == 0) ? 0 : 8);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    check({tag, "_q"}, 32'(quotient), 32'(ref_q(a, b)));
    check({tag, "_r"}, 32'(remainder), 32'(ref_r(a, b)));
    check({tag, "_dbz"}, 32'(div_by_zero), (b == 0) ? 1 : 0);
    last_q = ref_q(a, b);
    last_r = ref_r(a, b);
    last_z = (b == 0) ? 1 : 0;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_r_held"}, 32'(remainder), 32'(last_r));
  endtask

  initial begin
    int bc;
    bit tmo;
    int cnt_done;
    int cnt_busy;
    int a;
    int b;
    int q;
    int r;
    int prod;

    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_check("d225_15", 225, 15);
    run_check("d200_7", 200, 7);
    run_check("d5_9", 5, 9);
    run_check("d255_1", 255, 1);
    run_check("d13_0", 13, 0);
    run_check("d225_15_clr", 225, 15);

    // start pulsed mid-run must be ignored
    launch(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd99;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(bc, tmo);
    check("ign_timeout", 32'(tmo), 0);
    check("ign_q", 32'(quotient), 28);
    check("ign_r", 32'(remainder), 4);
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
      if (busy === 1'b1) cnt_busy++;
    end
    check("ign_extra_done", 32'(cnt_done), 0);
    check("ign_extra_busy", 32'(cnt_busy), 0);
    last_q = 28;
    last_r = 4;

    // reset in the 4th RUN cycle
    launch(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_q", 32'(quotient), 0);
    check("mid_r", 32'(remainder), 0);
    check("mid_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
    end
    check("mid_no_done", 32'(cnt_done), 0);
    last_q = 0;
    last_r = 0;
    last_z = 0;
    run_check("d50_6", 50, 6);

    // random operands, zero divisor made more likely
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      run_check("rand", a, b);
    end

    // exhaustive sweep, each start issued in the previous DONE cycle
    launch(8'd0, 4'd0);
    for (int n = 0; n < 4096; n++) begin
      a = n >> 4;
      b = n & 15;
      wait_done(bc, tmo);
      check("sweep_timeout", 32'(tmo), 0);
      q = int'(quotient);
      r = int'(remainder);
      if (b == 0) begin
        check("sweep_dbz_set", 32'(div_by_zero), 1);
        check("sweep_dbz_q", 32'(q), 255);
        check("sweep_dbz_r", 32'(r), 32'(a % 16));
      end else begin
        prod = (q < 16) ? vedic4x4(4'(q), 4'(b)) : q * b;
        check("sweep_dbz_clr", 32'(div_by_zero), 0);
        check("sweep_inv", 32'(prod + r), 32'(a));
        check("sweep_r_lt_d", 32'(r < b), 1);
      end
      if (n < 4095) launch(8'((n + 1) >> 4), 4'((n + 1) & 15));
    end
    @(negedge clk);
    check("sweep_end_done", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
